// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Holds the FSM state encoding, one-hot grant constants and the default
// watchdog limit used when ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a last-grant pointer register.
// Latency: grant is combinational from i_req; pointer updates one edge after i_upd.
// Backpressure: none; the caller decides when a grant is consumed via i_upd.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset (pointer -> m1)
//   i_req[1:0]         request vector (bit0=m0, bit1=m1)
//   i_upd              pulse: commit the finished owner to the pointer
//   i_upd_last_m1      finished owner was m1 (1) or m0 (0)
//   o_gnt[1:0]         one-hot winner, 00 when nobody requests
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_last_m1,
    output logic [1:0] o_gnt
);

    // 1 = m1 was granted last, so m0 wins the next tie.
    logic r_last_m1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_m1 <= 1'b1;
        end else if (i_upd) begin
            r_last_m1 <= i_upd_last_m1;
        end
    end

    always_comb begin
        o_gnt = GNT_NONE;
        case (i_req)
            2'b01:   o_gnt = GNT_M0;
            2'b10:   o_gnt = GNT_M1;
            2'b11:   o_gnt = r_last_m1 ? GNT_M0 : GNT_M1;
            default: o_gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters (m0 LSU, m1 fetch/loader) share one SRAM controller.
// Latency: req->ack = downstream latency + 2 cycles (IDLE sample, BUSY, DONE ack).
// Backpressure: one transaction in flight; requesters wait with req held until ack.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_mX_req/wren/addr/wdata/control     requester X command (level request)
//   o_mX_ack, o_mX_rdata                 requester X completion pulse and load data
//   o_s_rden/o_s_wren/addr/wdata/control downstream command, held until i_s_ack
//   i_s_ack, i_s_rdata                   downstream completion and load data
//   o_grant                              one-hot current owner, 00 when idle
//   o_err                                sticky watchdog timeout flag
// Build option: define ARB_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYC
// cycles); otherwise BUSY waits indefinitely for i_s_ack and o_err is 0.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_m0_req,
    input  logic              i_m0_wren,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [31:0]       i_m0_wdata,
    input  logic [2:0]        i_m0_control,
    output logic              o_m0_ack,
    output logic [31:0]       o_m0_rdata,

    input  logic              i_m1_req,
    input  logic              i_m1_wren,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [31:0]       i_m1_wdata,
    input  logic [2:0]        i_m1_control,
    output logic              o_m1_ack,
    output logic [31:0]       o_m1_rdata,

    output logic              o_s_rden,
    output logic              o_s_wren,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [31:0]       o_s_wdata,
    output logic [2:0]        o_s_control,
    input  logic              i_s_ack,
    input  logic [31:0]       i_s_rdata,

    output logic [1:0]        o_grant,
    output logic              o_err
);

    arb_state_t        r_state;
    logic [1:0]        r_grant;
    logic [1:0]        r_ack;
    logic [1:0]        r_rd_owner;   // which requester the captured rdata belongs to
    logic [31:0]       r_rdata;
    logic              r_s_rden;
    logic              r_s_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_control;

    logic [1:0]        w_arb_gnt;
    logic              w_sel_wren;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [2:0]        w_sel_control;

`ifdef ARB_TIMEOUT_EN
    // Counter holds the number of completed BUSY cycles; the last allowed
    // BUSY cycle is the one where it equals TIMEOUT_CYC-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_tmo_cnt;
    logic        r_err;
`else
    logic [15:0] w_unused_tmo;
    assign w_unused_tmo = 16'(TIMEOUT_CYC);
`endif

    rr_arb2 u_rr_arb2 (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         ({i_m1_req, i_m0_req}),
        .i_upd         (r_state == ST_DONE),
        .i_upd_last_m1 (r_grant[1]),
        .o_gnt         (w_arb_gnt)
    );

    // Winner's command, only meaningful when w_arb_gnt is non-zero.
    always_comb begin
        w_sel_wren    = i_m0_wren;
        w_sel_addr    = i_m0_addr;
        w_sel_wdata   = i_m0_wdata;
        w_sel_control = i_m0_control;
        if (w_arb_gnt[1]) begin
            w_sel_wren    = i_m1_wren;
            w_sel_addr    = i_m1_addr;
            w_sel_wdata   = i_m1_wdata;
            w_sel_control = i_m1_control;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= GNT_NONE;
            r_ack      <= GNT_NONE;
            r_rd_owner <= GNT_NONE;
            r_rdata    <= '0;
            r_s_rden   <= 1'b0;
            r_s_wren   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_control  <= '0;
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            // Acks are single-cycle: only the BUSY->DONE transition sets them.
            r_ack <= GNT_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_gnt != GNT_NONE) begin
                        r_grant   <= w_arb_gnt;
                        r_addr    <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_control <= w_sel_control;
                        r_s_rden  <= ~w_sel_wren;
                        r_s_wren  <= w_sel_wren;
`ifdef ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_s_ack) begin
                        r_rdata    <= i_s_rdata;
                        r_rd_owner <= r_grant;
                        r_s_rden   <= 1'b0;
                        r_s_wren   <= 1'b0;
                        r_ack      <= r_grant;
                        r_state    <= ST_DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        // Give up on the downstream: complete with zero data.
                        r_rdata    <= '0;
                        r_rd_owner <= r_grant;
                        r_s_rden   <= 1'b0;
                        r_s_wren   <= 1'b0;
                        r_ack      <= r_grant;
                        r_err      <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_tmo_cnt  <= r_tmo_cnt + 16'd1;
                    end
`endif
                end
                ST_DONE: begin
                    r_grant <= GNT_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_m0_ack    = r_ack[0];
    assign o_m1_ack    = r_ack[1];
    assign o_m0_rdata  = r_rd_owner[0] ? r_rdata : 32'h0;
    assign o_m1_rdata  = r_rd_owner[1] ? r_rdata : 32'h0;
    assign o_s_rden    = r_s_rden;
    assign o_s_wren    = r_s_wren;
    assign o_s_addr    = r_addr;
    assign o_s_wdata   = r_wdata;
    assign o_s_control = r_control;
    assign o_grant     = r_grant;
`ifdef ARB_TIMEOUT_EN
    assign o_err       = r_err;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single load, minimum latency, store
// stability, round-robin ties, mid-BUSY reset, spurious ack and watchdog.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_wren, m1_req, m1_wren;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic [2:0]        m0_control, m1_control;
    logic              m0_ack, m1_ack;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              s_rden, s_wren, s_ack;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata, s_rdata;
    logic [2:0]        s_control;
    logic [1:0]        grant;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_control(m0_control),
        .o_m0_ack(m0_ack), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_control(m1_control),
        .o_m1_ack(m1_ack), .o_m1_rdata(m1_rdata),
        .o_s_rden(s_rden), .o_s_wren(s_wren), .o_s_addr(s_addr),
        .o_s_wdata(s_wdata), .o_s_control(s_control),
        .i_s_ack(s_ack), .i_s_rdata(s_rdata),
        .o_grant(grant), .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_wren = 0; m0_addr = '0; m0_wdata = '0; m0_control = '0;
        m1_req = 0; m1_wren = 0; m1_addr = '0; m1_wdata = '0; m1_control = '0;
        s_ack = 0; s_rdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_rden", 32'(s_rden), 32'h0);
        chk("rst_wren", 32'(s_wren), 32'h0);
        chk("rst_ack", 32'({m1_ack, m0_ack}), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);

        // Spurious downstream ack while idle
        s_ack = 1; s_rdata = 32'hBAD0_BAD0;
        tick();
        s_ack = 0;
        chk("spur_ack", 32'({m1_ack, m0_ack}), 32'h0);
        chk("spur_grant", 32'(grant), 32'h0);
        chk("spur_rden", 32'(s_rden), 32'h0);
        tick();
        chk("spur_rdata", m0_rdata, 32'h0);

        // Single m0 load, downstream acks 3 cycles after rden rises
        m0_req = 1; m0_wren = 0; m0_addr = 16'h2004; m0_control = 3'b010;
        tick();
        m0_req = 0; m0_addr = 16'h0000;   // change while BUSY must be ignored
        chk("ld_rden", 32'(s_rden), 32'h1);
        chk("ld_wren", 32'(s_wren), 32'h0);
        chk("ld_grant", 32'(grant), 32'h1);
        chk("ld_addr", 32'(s_addr), 32'h2004);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_wait_ack", 32'({m1_ack, m0_ack}), 32'h0);
            chk("ld_wait_addr", 32'(s_addr), 32'h2004);
        end
        s_ack = 1; s_rdata = 32'hDEADBEEF;
        tick();
        s_ack = 0; s_rdata = '0;
        chk("ld_m0_ack", 32'(m0_ack), 32'h1);
        chk("ld_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("ld_m1_ack", 32'(m1_ack), 32'h0);
        chk("ld_m1_rdata", m1_rdata, 32'h0);
        chk("ld_rden_drop", 32'(s_rden), 32'h0);
        tick();
        chk("ld_ack_pulse", 32'(m0_ack), 32'h0);
        chk("ld_grant_clr", 32'(grant), 32'h0);

        // Minimum latency: m1 load acked in first BUSY cycle
        m1_req = 1; m1_wren = 0; m1_addr = 16'h0040;
        tick();
        m1_req = 0;
        chk("min_grant", 32'(grant), 32'h2);
        s_ack = 1; s_rdata = 32'hA5A5_0001;
        tick();
        s_ack = 0;
        chk("min_m1_ack", 32'(m1_ack), 32'h1);
        chk("min_m1_rdata", m1_rdata, 32'hA5A5_0001);
        chk("min_m0_rdata", m0_rdata, 32'h0);
        tick();

        // m1 store, fields stable until downstream ack
        m1_req = 1; m1_wren = 1; m1_addr = 16'h3010; m1_wdata = 32'h12345678; m1_control = 3'b010;
        tick();
        m1_req = 0; m1_addr = 16'hFFFF; m1_wdata = 32'h0; m1_control = 3'b111;
        chk("st_wren", 32'(s_wren), 32'h1);
        chk("st_rden", 32'(s_rden), 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("st_addr", 32'(s_addr), 32'h3010);
            chk("st_wdata", s_wdata, 32'h12345678);
            chk("st_ctrl", 32'(s_control), 32'h2);
            tick();
        end
        s_ack = 1;
        tick();
        s_ack = 0;
        chk("st_m1_ack", 32'(m1_ack), 32'h1);
        chk("st_wren_drop", 32'(s_wren), 32'h0);
        tick();
        m1_wren = 0;

        // Both requesting, held: m1 went last, so m0,m1,m0,m1
        m0_req = 1; m1_req = 1; m0_addr = 16'h0100; m1_addr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("rr_grant", 32'(grant), 32'(exp_g));
            chk("rr_addr", 32'(s_addr), (i % 2 == 0) ? 32'h0100 : 32'h0200);
            s_ack = 1; s_rdata = 32'(i);
            tick();
            s_ack = 0;
            chk("rr_ack", 32'({m1_ack, m0_ack}), 32'(exp_g));
            tick();
            chk("rr_idle_gap", 32'(grant), 32'h0);
        end
        m0_req = 0; m1_req = 0;
        tick();

        // Reset during the 2nd BUSY cycle; pointer must return to m1
        m0_req = 1;                       // m0 goes last, so a tie would favour m1
        tick();
        m0_req = 0; s_ack = 1;
        tick();
        s_ack = 0;
        tick();
        m1_req = 1;
        tick();
        chk("rb_grant_m1", 32'(grant), 32'h2);
        tick();
        rst = 1; m1_req = 0;
        tick();
        rst = 0;
        chk("rb_rden", 32'(s_rden), 32'h0);
        chk("rb_grant", 32'(grant), 32'h0);
        chk("rb_ack", 32'({m1_ack, m0_ack}), 32'h0);
        chk("rb_addr", 32'(s_addr), 32'h0);
        m0_req = 1; m1_req = 1;
        tick();
        chk("rb_tie_m0", 32'(grant), 32'h1);
        m1_req = 0; m0_req = 0;
        s_ack = 1; s_rdata = 32'h55AA_33CC;
        tick();
        s_ack = 0;
        chk("rb_m0_rdata", m0_rdata, 32'h55AA_33CC);
        tick();

        // Watchdog: m0 load with no downstream ack
        m0_req = 1;
        tick();
        m0_req = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wd_busy_ack", 32'(m0_ack), 32'h0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        chk("wd_ack", 32'(m0_ack), 32'h1);
        chk("wd_rdata", m0_rdata, 32'h0);
        chk("wd_err", 32'(err), 32'h1);
        tick(); tick();
        chk("wd_err_sticky", 32'(err), 32'h1);
        chk("wd_idle", 32'(grant), 32'h0);
`else
        chk("wd_still_busy", 32'(s_rden), 32'h1);
        chk("wd_no_ack", 32'(m0_ack), 32'h0);
        chk("wd_err", 32'(err), 32'h0);
        tick(); tick();
        chk("wd_hold_grant", 32'(grant), 32'h1);
`endif
        rst = 1;
        tick();
        rst = 0;
        chk("wd_err_clr", 32'(err), 32'h0);
        chk("wd_rden_clr", 32'(s_rden), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
